// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave-state type.
// Used by ahb_slave_mem and its register file.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

endpackage

// File: rtl/ahb_slave_regfile.sv
// Word register file: sync write, comb read, async clear.
// Depth 2^ADDR_W words of 32 bits.
module ahb_slave_regfile #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word slave: register-file memory, programmable
// wait states, two-cycle ERROR response.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int AW = ADDR_W + 2;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  slv_state_e    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;

  logic        rdy;
  logic        acc;
  logic        err;
  logic        we;
  logic [31:0] rdata;

  logic unused_bits;
  assign unused_bits = ^{haddr[31:AW], htrans[0]};

  // Ready is a pure function of state so acc has no comb loop.
  always_comb begin
    rdy = 1'b1;
    case (state_q)
      ST_DATA: rdy = (cnt_q == 3'd0);
      ST_ERR1: rdy = 1'b0;
      default: rdy = 1'b1;
    endcase
  end

  assign acc = hsel & htrans[1] & hready & rdy;
  assign err = (hsize != HSIZE_WORD) | (haddr[1:0] != 2'b00);
  assign we  = (state_q == ST_DATA) & (cnt_q == 3'd0) & write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    case (state_q)
      ST_DATA: if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
      ST_ERR1: state_d = ST_ERR2;
      default: ;
    endcase
    if (rdy) begin
      state_d = ST_IDLE;
      if (acc) begin
        addr_d  = haddr[AW-1:0];
        write_d = hwrite;
        state_d = err ? ST_ERR1 : ST_DATA;
        cnt_d   = err ? 3'd0 : WS;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

  ahb_slave_regfile #(.ADDR_W(ADDR_W)) u_rf (
    .clk   (hclk),
    .rst_n (hresetn),
    .we    (we),
    .waddr (addr_q[AW-1:2]),
    .wdata (hwdata),
    .raddr (addr_q[AW-1:2]),
    .rdata (rdata)
  );

  assign hreadyout = rdy;
  assign hresp     = ((state_q == ST_ERR1) | (state_q == ST_ERR2))
                     ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = ((state_q == ST_DATA) & ~write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one slave with one wait
// state and one with none, sharing the master-side signals.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hready;
  logic        hr_en;
  logic        use0;
  logic [31:0] hwdata;
  logic        hro0, hro1;
  logic        hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 hclk = ~hclk;

  assign hready = hr_en & (use0 ? hro0 : hro1);

  ahb_slave_mem #(.ADDR_W(4), .WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .htrans(htrans), .hready(hready), .hwdata(hwdata),
    .hreadyout(hro1), .hresp(hresp1), .hrdata(hrdata1)
  );

  ahb_slave_mem #(.ADDR_W(4), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .htrans(htrans), .hready(hready), .hwdata(hwdata),
    .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    haddr  = '0;
    hsize  = HSIZE_WORD;
  endtask

  task automatic addr1(input logic wr, input logic [31:0] a,
                       input logic [2:0] sz);
    hsel1  = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic wr1(input string tag, input logic [31:0] a,
                     input logic [31:0] d);
    addr1(1'b1, a, HSIZE_WORD);
    step();
    bus_idle();
    hwdata = d;
    @(negedge hclk);
    check({tag, "_wait"}, 32'(hro1), 32'd0);
    step();
    @(negedge hclk);
    check({tag, "_done"}, {30'd0, hro1, hresp1}, 32'd2);
    step();
  endtask

  task automatic rd1(input string tag, input logic [31:0] a,
                     input logic [31:0] exp);
    addr1(1'b0, a, HSIZE_WORD);
    step();
    bus_idle();
    @(negedge hclk);
    check({tag, "_wait"}, 32'(hro1), 32'd0);
    step();
    @(negedge hclk);
    check({tag, "_done"}, {30'd0, hro1, hresp1}, 32'd2);
    check({tag, "_data"}, hrdata1, exp);
    step();
  endtask

  task automatic err1(input string tag, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz);
    addr1(wr, a, sz);
    step();
    bus_idle();
    hwdata = 32'h0BAD_0BAD;
    @(negedge hclk);
    check({tag, "_c1"}, {30'd0, hro1, hresp1}, 32'd1);
    check({tag, "_rd0"}, hrdata1, 32'd0);
    step();
    @(negedge hclk);
    check({tag, "_c2"}, {30'd0, hro1, hresp1}, 32'd3);
    step();
  endtask

  initial begin
    bus_idle();
    hwdata = '0;
    hr_en  = 1'b1;
    use0   = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_hro1", 32'(hro1), 32'd1);
    check("rst_hresp1", 32'(hresp1), 32'd0);
    check("rst_hrdata1", hrdata1, 32'd0);
    check("rst_hro0", 32'(hro0), 32'd1);
    hresetn = 1'b1;
    step();

    // write then read, one wait state
    wr1("wr8", 32'h8, 32'hDEAD_BEEF);
    rd1("rd8", 32'h8, 32'hDEAD_BEEF);

    // back-to-back on the zero-wait slave
    use0   = 1'b1;
    hsel0  = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    haddr  = 32'h4;
    step();
    hwdata = 32'h11;
    hwrite = 1'b0;
    @(negedge hclk);
    check("b2b_wr_done", {30'd0, hro0, hresp0}, 32'd2);
    step();
    bus_idle();
    @(negedge hclk);
    check("b2b_rd_done", {30'd0, hro0, hresp0}, 32'd2);
    check("b2b_rd_data", hrdata0, 32'h11);
    step();
    use0 = 1'b0;

    // error responses
    err1("err_size", 1'b0, 32'h0, 3'b000);
    err1("err_align", 1'b1, 32'h2, HSIZE_WORD);
    rd1("err_mem0", 32'h0, 32'h0);

    // no accept: hsel low, htrans idle, hready low
    hsel1 = 1'b0; htrans = HTRANS_NONSEQ;
    hwrite = 1'b1; haddr = 32'hC;
    step();
    hwdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    check("nosel_hro", 32'(hro1), 32'd1);
    hsel1 = 1'b1; htrans = HTRANS_IDLE;
    step();
    @(negedge hclk);
    check("noidle_hro", 32'(hro1), 32'd1);
    htrans = HTRANS_NONSEQ; hr_en = 1'b0;
    step();
    @(negedge hclk);
    check("nordy_hro", 32'(hro1), 32'd1);
    hr_en = 1'b1;
    bus_idle();
    step();
    rd1("nosel_mem3", 32'hC, 32'h0);

    // address wrap
    wr1("wrap_wr", 32'h40, 32'h5A);
    rd1("wrap_rd", 32'h0, 32'h5A);

    // reset in a write wait state
    addr1(1'b1, 32'h10, HSIZE_WORD);
    step();
    bus_idle();
    hwdata = 32'h77;
    @(negedge hclk);
    check("rmid_wait", 32'(hro1), 32'd0);
    hresetn = 1'b0;
    #1;
    check("rmid_hro", 32'(hro1), 32'd1);
    check("rmid_hresp", 32'(hresp1), 32'd0);
    check("rmid_hrdata", hrdata1, 32'd0);
    step();
    hresetn = 1'b1;
    step();
    rd1("rmid_mem4", 32'h10, 32'h0);
    rd1("rmid_mem2", 32'h8, 32'h0);
    rd1("rmid_mem0", 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

Word-addressed AHB slave with a small register-file memory and a programmable wait-state count. It sits directly downstream of `ahb_master`, reached through the interconnect's slave select. It consumes `haddr`, `hwrite`, `hsize`, `htrans`, `hready` and `hwdata`, and returns `hrdata` and `hreadyout`. The system instantiates four copies, one per slave slot.

## Interface
Parameters:
- `ADDR_W`, default 4: word-address bits; depth = 2^ADDR_W words of 32 bits.
- `WAIT_STATES`, default 1: wait cycles inserted in every OKAY data phase; legal range 0..7.

Ports:
- `hclk` in 1: the only clock; all state changes on its rising edge.
- `hresetn` in 1: reset, asynchronous, active-low.
- `hsel` in 1: slave select from the interconnect decoder.
- `haddr` in 32: byte address; only `haddr[ADDR_W+1:0]` is used.
- `hwrite` in 1: 1 = write, 0 = read.
- `hsize` in 3: transfer size; only `3'b010` (word) is legal.
- `htrans` in 2: transfer type; 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hready` in 1: bus ready qualifier driven by the master.
- `hwdata` in 32: write data, valid during the write data phase.
- `hreadyout` out 1: 1 = current data phase completes this cycle.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out 32: read data.

## Operation
Address-phase accept:
- `acc = hsel & htrans[1] & hready & hreadyout`.
- On `acc` the slave registers `haddr`, `hwrite` and an error flag.
- `err = (hsize != 3'b010) | (haddr[1:0] != 2'b00)`.

State machine (ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2):
- ST_IDLE:
  - `hreadyout` = 1, `hresp` = 0.
  - `acc & !err` → ST_DATA, wait counter loaded with `WAIT_STATES`.
  - `acc & err` → ST_ERR1.
  - Otherwise stay. IDLE and BUSY transfers get a zero-wait OKAY.
- ST_DATA:
  - `hreadyout = (cnt == 0)`; `cnt` decrements while nonzero.
  - When `cnt == 0`, the phase completes. A write commits `mem[addr_q[ADDR_W+1:2]] <= hwdata` at this edge.
  - In that same cycle a new `acc` is honoured (back-to-back pipelining): next state is ST_DATA or ST_ERR1 per the new transfer. Without `acc`, next state is ST_IDLE.
- ST_ERR1: `hreadyout` = 0, `hresp` = 1; → ST_ERR2.
- ST_ERR2:
  - `hreadyout` = 1, `hresp` = 1. Memory is never written on an error.
  - `acc` is evaluated as in ST_IDLE; otherwise → ST_IDLE.

Read data and memory:
- `hrdata = mem[addr_q]` while in ST_DATA with a read; `32'h0` in every other state.
- The memory read is combinational from the registered address. A read that directly follows a write to the same word therefore returns the new value.

## Timing
- Reset (any time, including mid-transfer):
  - State → ST_IDLE, `cnt` = 0, `hreadyout` = 1, `hresp` = 0, `hrdata` = 0.
  - All memory words cleared to 0.
  - An in-flight write is discarded.
- OKAY transfer latency: the address is accepted at edge N. `hreadyout` is low for cycles N+1 .. N+WAIT_STATES and high in cycle N+WAIT_STATES+1. With `WAIT_STATES = 0` the data phase completes in cycle N+1.
- ERROR transfer: exactly two data-phase cycles, (0,1) then (1,1) on (`hreadyout`, `hresp`).
- Wait states are inserted on reads and writes alike.
- `hsel` low, or `hready` low, during an address phase means no accept; current state is unaffected.
- The address wraps modulo the depth: word index `2^ADDR_W` maps to 0.

## Structure
- Shared package `ahb_pkg` holds:
  - HTRANS codes: `HTRANS_IDLE`, `HTRANS_BUSY`, `HTRANS_NONSEQ`, `HTRANS_SEQ`.
  - `HSIZE_WORD` = `3'b010`.
  - `HRESP_OKAY` / `HRESP_ERROR`.
  - The slave-state encoding.
- One sub-module, `ahb_slave_regfile`: a 2^ADDR_W × 32 array with a synchronous write port, a combinational read port and asynchronous clear.
- The FSM, wait counter and address/control registers stay in the top.

## Test plan
- Write then read, `WAIT_STATES = 1`: write `32'hDEAD_BEEF` to `haddr = 0x8`, then read `0x8`. Each data phase has `hreadyout` = 0 for one cycle; read returns `32'hDEAD_BEEF` with `hresp` = 0.
- Back-to-back, `WAIT_STATES = 0`: NONSEQ write `0x4` = `0x11` then an immediate read of `0x4`. The read data phase returns `0x11` one cycle after the write completes, with no idle cycle between.
- Error: read with `hsize = 3'b000` at `0x0`, and a write to `0x2`. Each gives `hreadyout`/`hresp` = 0/1 then 1/1; memory word 0 is unchanged (0).
- No selection: `hsel = 0`, or `htrans = IDLE`, or `hready = 0` with a write to `0xC`. `hreadyout` stays 1 and word 3 stays 0.
- Reset mid-operation: assert `hresetn = 0` during a wait state of a write to `0x10`. Outputs return to reset values immediately and a subsequent read of `0x10` returns 0.
- Wrap, `ADDR_W = 4`: write `0x5A` to `haddr = 0x40`, read `0x0` → `0x5A`.
